sync_fifo_ctl: RTL



---
 rtl/sync_fifo_ctl.sv | 76 +++++++
 1 files changed

// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO controller with fill level, almost flags and optional sticky error flags (SYNC_FIFO_ERR_FLAG_EN)
module sync_fifo_ctl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AFULL_TH = 12,
  parameter int AEMPTY_TH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rinc,
  output logic [WIDTH-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [CW-1:0]    fill_cnt,
  output logic             overflow,
  output logic             underflow
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rdata;
  logic             w_wen, w_ren;

  assign w_wen         = winc & ~wfull;
  assign w_ren         = rinc & ~rempty;
  assign rempty        = (r_cnt == '0);
  assign wfull         = (r_cnt == CW'(DEPTH));
  assign walmost_full  = (r_cnt >= CW'(AFULL_TH));
  assign ralmost_empty = (r_cnt <= CW'(AEMPTY_TH));
  assign fill_cnt      = r_cnt;
  assign rdata         = r_rdata;

  // storage is never reset; only accepted writes touch it
  always_ff @(posedge clk)
    if (w_wen) r_mem[r_wptr] <= wdata;

  // pointers wrap by explicit compare so DEPTH need not be a power of two
  always_ff @(posedge clk)
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wen) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_ren) begin
        r_rptr  <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr];
      end
      r_cnt <= r_cnt + CW'(w_wen) - CW'(w_ren);
    end

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic r_ovf, r_udf;
  // sticky error flags, cleared only by reset
  always_ff @(posedge clk)
    if (!rstn) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (winc & wfull)  r_ovf <= 1'b1;
      if (rinc & rempty) r_udf <= 1'b1;
    end
  assign overflow  = r_ovf;
  assign underflow = r_udf;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule
